// File: rtl/button_press_classifier_if.sv
// Signal bundle for button_press_classifier: raw button in, debounced level and gesture pulses out.
// The master side drives the raw button level; the slave side is the classifier.
interface button_press_classifier_if;
    logic btn;
    logic btn_level;
    logic set_short;
    logic set_double;
    logic set_triple;
    logic set_four;
    logic set_long;

    modport master (
        output btn,
        input  btn_level,
        input  set_short,
        input  set_double,
        input  set_triple,
        input  set_four,
        input  set_long
    );

    modport slave (
        input  btn,
        output btn_level,
        output set_short,
        output set_double,
        output set_triple,
        output set_four,
        output set_long
    );
endinterface

// File: rtl/button_press_classifier.sv
// Synchronises and debounces a raw push button, then classifies presses into single, double,
// triple, four-or-more clicks and long presses, each reported as a registered one-cycle pulse.
module button_press_classifier #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned LONG_CYCLES     = 100_000_000,
    parameter int unsigned GAP_CYCLES      = 30_000_000
) (
    input logic                      clk,
    input logic                      reset_n,
    button_press_classifier_if.slave bus
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned HoldW = $clog2(LONG_CYCLES) + 1;
    localparam int unsigned GapW  = $clog2(GAP_CYCLES) + 1;

    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_CYCLES);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [GapW-1:0]  GapMax   = GapW'(GAP_CYCLES);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPressed  = 2'd1;
    localparam logic [1:0] StWaitGap  = 2'd2;
    localparam logic [1:0] StLongHeld = 2'd3;

    // Pulse vector bit order: short, double, triple, four, long.
    localparam int unsigned PShort  = 0;
    localparam int unsigned PDouble = 1;
    localparam int unsigned PTriple = 2;
    localparam int unsigned PFour   = 3;
    localparam int unsigned PLong   = 4;

    logic [1:0]       sync_q, sync_d;
    logic [DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [1:0]       state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;
    logic [GapW-1:0]  gap_q, gap_d;
    logic [2:0]       clicks_q, clicks_d;
    logic [4:0]       pulse_q, pulse_d;

    logic rise;
    logic fall;

    assign rise = level_q & ~level_prev_q;
    assign fall = ~level_q & level_prev_q;

    always_comb begin
        sync_d    = {sync_q[0], bus.btn};
        deb_cnt_d = '0;
        level_d   = level_q;
        if (sync_q[1] != level_q) begin
            if (deb_cnt_q == DebLast) begin
                level_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        clicks_d = clicks_q;
        pulse_d  = '0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    hold_d  = '0;
                    state_d = StPressed;
                end
            end
            StPressed: begin
                // A release seen in the final counting cycle still counts as a click.
                if (fall) begin
                    clicks_d = (clicks_q == 3'd4) ? 3'd4 : clicks_q + 3'd1;
                    gap_d    = '0;
                    state_d  = StWaitGap;
                end else if (hold_q == HoldLast) begin
                    pulse_d[PLong] = 1'b1;
                    clicks_d       = '0;
                    state_d        = StLongHeld;
                end else if (hold_q != HoldMax) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            StWaitGap: begin
                // Gap expiry wins over a coincident press; that press is dropped.
                if (gap_q == GapLast) begin
                    case (clicks_q)
                        3'd1:    pulse_d[PShort]  = 1'b1;
                        3'd2:    pulse_d[PDouble] = 1'b1;
                        3'd3:    pulse_d[PTriple] = 1'b1;
                        3'd4:    pulse_d[PFour]   = 1'b1;
                        default: pulse_d          = '0;
                    endcase
                    clicks_d = '0;
                    state_d  = StIdle;
                end else if (rise) begin
                    hold_d  = '0;
                    state_d = StPressed;
                end else if (gap_q != GapMax) begin
                    gap_d = gap_q + 1'b1;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                clicks_d = '0;
                state_d  = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q       <= '0;
            deb_cnt_q    <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            state_q      <= StIdle;
            hold_q       <= '0;
            gap_q        <= '0;
            clicks_q     <= '0;
            pulse_q      <= '0;
        end else begin
            sync_q       <= sync_d;
            deb_cnt_q    <= deb_cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            state_q      <= state_d;
            hold_q       <= hold_d;
            gap_q        <= gap_d;
            clicks_q     <= clicks_d;
            pulse_q      <= pulse_d;
        end
    end

    assign bus.btn_level  = level_q;
    assign bus.set_short  = pulse_q[PShort];
    assign bus.set_double = pulse_q[PDouble];
    assign bus.set_triple = pulse_q[PTriple];
    assign bus.set_four   = pulse_q[PFour];
    assign bus.set_long   = pulse_q[PLong];

endmodule
